pipe_tracker: RTL and testbench
===============================

// Module: pipe_tracker
// PURPOSE
// - Parametrised in-order pipeline tracker for the microcoded RV32 core.
// - Carries {valid, pc, microcode, instruction_data} from decode (s0) through STAGES stages.
// - Detects register RAW hazards against older stages, inserts bubbles, applies ext_hold
//   and branch flush, and exposes every stage's payload to the datapath.
// - Supersedes the fixed hand-wired s0..s3 buffers in the core top.
// PARAMETERS
// - STAGES       4   pipeline depth, 3..8; stage STAGES-1 is writeback
// - PC_W         30  word-address PC width
// - UCODE_W      32  microcode word width
// - IDATA_W      25  instruction_data width; rd=[4:0], rs1=[12:8], rs2=[17:13]
// - REG_WE_BIT   0   microcode bit meaning "stage writes rd"
// - FLUSH_DEPTH  2   stages 0..FLUSH_DEPTH-1 are killed by flush; range 1..STAGES-2
// PORTS
// - clk          in   1                  rising-edge clock
// - rst_n        in   1                  asynchronous active-low reset
// - in_valid     in   1                  decoder presents a new instruction
// - in_pc        in   PC_W               PC of new instruction
// - in_ucode     in   UCODE_W            microcode of new instruction
// - in_idata     in   IDATA_W            instruction_data of new instruction
// - in_ready     out  1                  = !ext_hold && !hazard && !flush
// - ext_hold     in   1                  freeze entire pipeline (memory busy)
// - flush        in   1                  branch taken; branching instr sits in stage FLUSH_DEPTH
// - hazard       out  1                  RAW hazard on stage 0 (combinational)
// - stage_valid  out  STAGES             valid bit per stage, bit k = stage k
// - stage_pc     out  STAGES*PC_W        flattened, stage k at [k*PC_W +: PC_W]
// - stage_ucode  out  STAGES*UCODE_W     flattened, same packing
// - stage_idata  out  STAGES*IDATA_W     flattened, same packing
// - retire       out  1                  stage STAGES-1 valid and leaving this cycle
// BEHAVIOUR
// - Reset (async, rst_n=0): all stage_valid=0, all payloads 0; outputs follow immediately.
//   Reset mid-operation drops every in-flight instruction; no retire while rst_n=0.
// - Latency: accepted at edge E -> stage k holds it after edge E+k when no stall/hold.
// - Accept: stage 0 loads in_* with valid=in_valid at an edge where in_ready=1.
// - hazard = stage_valid[0] && exists k in 1..STAGES-1: stage_valid[k] && ucode_k[REG_WE_BIT]
//   && rd_k!=0 && (rd_k==rs1_0 || rd_k==rs2_0). x0 never hazards.
// - Priority per edge: ext_hold > flush > hazard > normal advance.
// - ext_hold=1: no register changes; retire=0; flush/hazard ignored that edge.
// - flush=1 (no hold): stages >=FLUSH_DEPTH shift by one; stage FLUSH_DEPTH receives a bubble
//   (valid=0); stages 0..FLUSH_DEPTH-1 valid cleared; in_* not accepted.
// - hazard=1 (no hold/flush): stage 0 frozen, stage 1 gets bubble, stages >=1 shift.
// - Normal: every stage k>=1 takes stage k-1; stage 0 takes input (valid=in_valid).
// - Bubbles keep payload but valid=0; consumers must gate on stage_valid.
// - retire = stage_valid[STAGES-1] && !ext_hold && rst_n.
// - flush while stage FLUSH_DEPTH invalid is legal and still kills younger stages.
// CONFIGURATION
// - PIPE_PERF_EN defined: adds outputs perf_retired, perf_bubbles, perf_flushes (32 b each),
//   reset to 0; increment on retire, on hazard-stall edges (not held), on flush edges
//   (not held); wrap modulo 2^32; perf_clr input (1 b) zeroes all three synchronously,
//   taking priority over increments.
// - PIPE_PERF_EN undefined: no counter ports or logic; all other behaviour identical.
// TESTING
// - Reset: rst_n=0 mid-stream with 4 valid stages -> stage_valid=4'b0000 before next edge,
//   retire=0.
// - Streaming: 6 back-to-back independent instrs pc=0..5 -> pc=0 in stage 3 after 4th
//   edge; retire high 6 consecutive cycles.
// - RAW: stage1 writes x5 (we=1), stage0 reads rs1=x5 -> hazard=1, in_ready=0; bubble in
//   stage1 until the writer leaves stage 3, then hazard=0; rs1=x0 vs rd=x0 -> hazard=0.
// - Flush: branch at stage2, valid stages 0,1, flush=1 -> next cycle stage_valid=4'b1000
//   (branch in stage3), in_* dropped.
// - Hold vs flush: ext_hold=1 and flush=1 together for 3 cycles -> all stage regs unchanged,
//   retire=0; hold drop with flush=1 -> flush applies.
// - PIPE_PERF_EN: 10 retires, 3 hazard edges, 1 flush -> counters 10/3/1; perf_clr -> 0/0/0.

Source files
------------

// File: rtl/pipe_tracker_if.sv
// Decode-to-writeback pipeline tracker bundle; perf counter signals exist only with PIPE_PERF_EN.
// slave is the tracker side, master is the decoder/datapath side.
interface pipe_tracker_if #(
  parameter int STAGES  = 4,
  parameter int PC_W    = 30,
  parameter int UCODE_W = 32,
  parameter int IDATA_W = 25
);
  logic                       in_valid;
  logic [PC_W-1:0]            in_pc;
  logic [UCODE_W-1:0]         in_ucode;
  logic [IDATA_W-1:0]         in_idata;
  logic                       in_ready;
  logic                       ext_hold;
  logic                       flush;
  logic                       hazard;
  logic [STAGES-1:0]          stage_valid;
  logic [STAGES*PC_W-1:0]     stage_pc;
  logic [STAGES*UCODE_W-1:0]  stage_ucode;
  logic [STAGES*IDATA_W-1:0]  stage_idata;
  logic                       retire;

`ifdef PIPE_PERF_EN
  logic                       perf_clr;
  logic [31:0]                perf_retired;
  logic [31:0]                perf_bubbles;
  logic [31:0]                perf_flushes;

  modport master (
    output in_valid, in_pc, in_ucode, in_idata, ext_hold, flush, perf_clr,
    input  in_ready, hazard, stage_valid, stage_pc, stage_ucode, stage_idata, retire,
    input  perf_retired, perf_bubbles, perf_flushes
  );
  modport slave (
    input  in_valid, in_pc, in_ucode, in_idata, ext_hold, flush, perf_clr,
    output in_ready, hazard, stage_valid, stage_pc, stage_ucode, stage_idata, retire,
    output perf_retired, perf_bubbles, perf_flushes
  );
`else
  modport master (
    output in_valid, in_pc, in_ucode, in_idata, ext_hold, flush,
    input  in_ready, hazard, stage_valid, stage_pc, stage_ucode, stage_idata, retire
  );
  modport slave (
    input  in_valid, in_pc, in_ucode, in_idata, ext_hold, flush,
    output in_ready, hazard, stage_valid, stage_pc, stage_ucode, stage_idata, retire
  );
`endif
endinterface

// File: rtl/pipe_tracker.sv
// In-order pipeline tracker: carries {valid, pc, ucode, idata} through STAGES stages with RAW
// stall, ext_hold freeze and branch flush. Define PIPE_PERF_EN to add the perf counters.
module pipe_tracker #(
  parameter int STAGES      = 4,
  parameter int PC_W        = 30,
  parameter int UCODE_W     = 32,
  parameter int IDATA_W     = 25,
  parameter int REG_WE_BIT  = 0,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_tracker_if.slave bus
);
  typedef enum logic [1:0] {ADV_NORMAL, ADV_HAZARD, ADV_FLUSH, ADV_HOLD} adv_t;

  logic [STAGES-1:0]  valid_reg;
  logic [PC_W-1:0]    pc_reg    [STAGES];
  logic [UCODE_W-1:0] ucode_reg [STAGES];
  logic [IDATA_W-1:0] idata_reg [STAGES];

  logic               valid_next [STAGES];
  logic [PC_W-1:0]    pc_next    [STAGES];
  logic [UCODE_W-1:0] ucode_next [STAGES];
  logic [IDATA_W-1:0] idata_next [STAGES];

  logic [STAGES-1:0]  raw_hit;
  logic [4:0]         rs1_0;
  logic [4:0]         rs2_0;
  logic               hazard;
  logic               retire;
  adv_t               mode;

  assign rs1_0 = idata_reg[0][12:8];
  assign rs2_0 = idata_reg[0][17:13];
  assign raw_hit[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_raw
      logic [4:0] rd;
      assign rd = idata_reg[gi][4:0];
      assign raw_hit[gi] = valid_reg[gi] && ucode_reg[gi][REG_WE_BIT] && (rd != 5'd0)
                           && ((rd == rs1_0) || (rd == rs2_0));
    end
  endgenerate

  assign hazard = valid_reg[0] && (|raw_hit);

  always_comb begin
    if (bus.ext_hold)   mode = ADV_HOLD;
    else if (bus.flush) mode = ADV_FLUSH;
    else if (hazard)    mode = ADV_HAZARD;
    else                mode = ADV_NORMAL;
  end

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        logic load_in;
        assign load_in        = (mode == ADV_NORMAL);
        assign pc_next[gi]    = load_in ? bus.in_pc    : pc_reg[gi];
        assign ucode_next[gi] = load_in ? bus.in_ucode : ucode_reg[gi];
        assign idata_next[gi] = load_in ? bus.in_idata : idata_reg[gi];
        assign valid_next[gi] = load_in ? bus.in_valid
                              : ((mode == ADV_FLUSH) ? 1'b0 : valid_reg[gi]);
      end else begin : g_body
        localparam bit BUBBLE_ON_HAZARD = (gi == 1);
        localparam bit BUBBLE_ON_FLUSH  = (gi == FLUSH_DEPTH);
        localparam bit KILLED_BY_FLUSH  = (gi < FLUSH_DEPTH);
        logic take_prev;
        logic make_bubble;
        // Bubbles copy the older payload but never its valid bit.
        assign take_prev   = (mode == ADV_NORMAL) || (mode == ADV_HAZARD)
                             || ((mode == ADV_FLUSH) && !KILLED_BY_FLUSH);
        assign make_bubble = ((mode == ADV_HAZARD) && BUBBLE_ON_HAZARD)
                             || ((mode == ADV_FLUSH) && BUBBLE_ON_FLUSH);
        assign pc_next[gi]    = take_prev ? pc_reg[gi-1]    : pc_reg[gi];
        assign ucode_next[gi] = take_prev ? ucode_reg[gi-1] : ucode_reg[gi];
        assign idata_next[gi] = take_prev ? idata_reg[gi-1] : idata_reg[gi];
        assign valid_next[gi] = take_prev ? (valid_reg[gi-1] && !make_bubble)
                              : ((mode == ADV_FLUSH) ? 1'b0 : valid_reg[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= 1'b0;
        pc_reg[k]    <= '0;
        ucode_reg[k] <= '0;
        idata_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= valid_next[k];
        pc_reg[k]    <= pc_next[k];
        ucode_reg[k] <= ucode_next[k];
        idata_reg[k] <= idata_next[k];
      end
    end
  end

  assign retire          = valid_reg[STAGES-1] && !bus.ext_hold && rst_n;
  assign bus.retire      = retire;
  assign bus.hazard      = hazard;
  assign bus.in_ready    = !bus.ext_hold && !hazard && !bus.flush;
  assign bus.stage_valid = valid_reg;

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_flat
      assign bus.stage_pc[gi*PC_W +: PC_W]          = pc_reg[gi];
      assign bus.stage_ucode[gi*UCODE_W +: UCODE_W] = ucode_reg[gi];
      assign bus.stage_idata[gi*IDATA_W +: IDATA_W] = idata_reg[gi];
    end
  endgenerate

`ifdef PIPE_PERF_EN
  logic [31:0] perf_retired_reg;
  logic [31:0] perf_bubbles_reg;
  logic [31:0] perf_flushes_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_reg <= '0;
      perf_bubbles_reg <= '0;
      perf_flushes_reg <= '0;
    end else if (bus.perf_clr) begin
      perf_retired_reg <= '0;
      perf_bubbles_reg <= '0;
      perf_flushes_reg <= '0;
    end else begin
      if (retire)              perf_retired_reg <= perf_retired_reg + 32'd1;
      if (mode == ADV_HAZARD)  perf_bubbles_reg <= perf_bubbles_reg + 32'd1;
      if (mode == ADV_FLUSH)   perf_flushes_reg <= perf_flushes_reg + 32'd1;
    end
  end

  assign bus.perf_retired = perf_retired_reg;
  assign bus.perf_bubbles = perf_bubbles_reg;
  assign bus.perf_flushes = perf_flushes_reg;
`endif
endmodule

// File: tb/tb_pipe_tracker.sv
// Directed bench for pipe_tracker: a stage-list model checked every cycle plus literal
// expectations for streaming, RAW stall, flush, hold and reset (PIPE_PERF_EN adds counter checks).
`timescale 1ns/1ps
module tb_pipe_tracker;
  localparam int S  = 4;
  localparam int PW = 30;
  localparam int UW = 32;
  localparam int IW = 25;
  localparam int FD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipe_tracker_if #(.STAGES(S), .PC_W(PW), .UCODE_W(UW), .IDATA_W(IW)) bus ();

  pipe_tracker #(.STAGES(S), .PC_W(PW), .UCODE_W(UW), .IDATA_W(IW),
                 .REG_WE_BIT(0), .FLUSH_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    bit            v;
    logic [PW-1:0] pc;
    logic [UW-1:0] uc;
    logic [IW-1:0] id;
  } ent_t;

  ent_t m [S];
  int total = 0;
  int bad = 0;
`ifdef PIPE_PERF_EN
  int m_ret = 0, m_bub = 0, m_fls = 0;
`endif

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hazard();
    logic [4:0] rs1, rs2, rd;
    if (!m[0].v) return 1'b0;
    rs1 = m[0].id[12:8];
    rs2 = m[0].id[17:13];
    for (int k = 1; k < S; k++) begin
      rd = m[k].id[4:0];
      if (m[k].v && m[k].uc[0] && rd != 5'd0 && (rd == rs1 || rd == rs2)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Model: an ordered list of stage entries, updated from the stated priority rules.
  always @(posedge clk or negedge rst_n) begin
    bit hz;
    if (!rst_n) begin
      for (int k = 0; k < S; k++) m[k] = '{default: 0};
`ifdef PIPE_PERF_EN
      m_ret = 0; m_bub = 0; m_fls = 0;
`endif
    end else begin
      hz = model_hazard();
`ifdef PIPE_PERF_EN
      if (bus.perf_clr) begin
        m_ret = 0; m_bub = 0; m_fls = 0;
      end else begin
        if (m[S-1].v && !bus.ext_hold) m_ret++;
        if (!bus.ext_hold && !bus.flush && hz) m_bub++;
        if (!bus.ext_hold && bus.flush) m_fls++;
      end
`endif
      if (!bus.ext_hold) begin
        if (bus.flush) begin
          for (int k = S-1; k > FD; k--) m[k] = m[k-1];
          m[FD] = m[FD-1];
          m[FD].v = 1'b0;
          for (int k = 0; k < FD; k++) m[k].v = 1'b0;
        end else if (hz) begin
          for (int k = S-1; k > 1; k--) m[k] = m[k-1];
          m[1] = m[0];
          m[1].v = 1'b0;
        end else begin
          for (int k = S-1; k > 0; k--) m[k] = m[k-1];
          m[0] = '{bus.in_valid, bus.in_pc, bus.in_ucode, bus.in_idata};
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [S-1:0] ev;
    bit hz;
    for (int k = 0; k < S; k++) ev[k] = m[k].v;
    hz = model_hazard();
    chk("cyc_valid",  bus.stage_valid, ev);
    chk("cyc_hazard", bus.hazard, hz);
    chk("cyc_ready",  bus.in_ready, !bus.ext_hold && !hz && !bus.flush);
    chk("cyc_retire", bus.retire, m[S-1].v && !bus.ext_hold && rst_n);
    for (int k = 0; k < S; k++) begin
      if (m[k].v) begin
        chk("cyc_pc",    bus.stage_pc[k*PW +: PW], m[k].pc);
        chk("cyc_ucode", bus.stage_ucode[k*UW +: UW], m[k].uc);
        chk("cyc_idata", bus.stage_idata[k*IW +: IW], m[k].id);
      end
    end
`ifdef PIPE_PERF_EN
    chk("cyc_perf_ret", bus.perf_retired, m_ret);
    chk("cyc_perf_bub", bus.perf_bubbles, m_bub);
    chk("cyc_perf_fls", bus.perf_flushes, m_fls);
`endif
  end

  function automatic logic [IW-1:0] mk(input int rd, input int rs1, input int rs2);
    logic [IW-1:0] r;
    r = '0;
    r[4:0]   = rd[4:0];
    r[12:8]  = rs1[4:0];
    r[17:13] = rs2[4:0];
    return r;
  endfunction

  function automatic logic [PW-1:0] pc_at(input int k);
    return bus.stage_pc[k*PW +: PW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input int pc, input logic [UW-1:0] uc, input logic [IW-1:0] id);
    bus.in_valid = v;
    bus.in_pc    = pc[PW-1:0];
    bus.in_ucode = uc;
    bus.in_idata = id;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.ext_hold = 1'b0;
    bus.flush    = 1'b0;
  endtask

  // Presents one instruction until the tracker accepts it (bounded).
  task automatic issue(input int pc, input logic [UW-1:0] uc, input logic [IW-1:0] id);
    bit ok;
    ok = 1'b0;
    drive(1'b1, pc, uc, id);
    for (int t = 0; t < 20 && !ok; t++) begin
      ok = bus.in_ready;
      tick();
    end
    chk("issue_accepted", ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rcnt, run, maxrun, hc;
    logic [S-1:0]    snap_v;
    logic [S*PW-1:0] snap_pc;

    idle();
    drive(1'b0, 0, '0, '0);
`ifdef PIPE_PERF_EN
    bus.perf_clr = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #1;
    chk("reset_valid",  bus.stage_valid, '0);
    chk("reset_retire", bus.retire, 1'b0);
    chk("reset_pc",     bus.stage_pc, '0);
    chk("reset_ucode",  bus.stage_ucode, '0);
    tick();
    rst_n = 1'b1;
    tick();

    // Streaming: pc 0..5 back to back.
    rcnt = 0; run = 0; maxrun = 0;
    for (int t = 0; t < 12; t++) begin
      if (t < 6) drive(1'b1, t, '0, mk(t+1, 0, 0));
      else       idle();
      tick();
      if (t == 3) begin
        chk("stream_pc3",    pc_at(3), 0);
        chk("stream_valid4", bus.stage_valid, 4'b1111);
      end
      if (bus.retire) begin
        rcnt++; run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end
    chk("stream_retires", rcnt, 6);
    chk("stream_run",     maxrun, 6);

    // Reset with four valid stages in flight.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 10+i, '0, mk(1, 0, 0));
      tick();
    end
    chk("rst_pre_valid", bus.stage_valid, 4'b1111);
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid",  bus.stage_valid, 4'b0000);
    chk("rst_mid_retire", bus.retire, 1'b0);
    chk("rst_mid_pc",     bus.stage_pc, '0);
    tick();
    rst_n = 1'b1;
    tick();

    // RAW: writer x5 then reader rs1=x5.
    drive(1'b1, 20, 32'h1, mk(5, 0, 0));
    tick();
    drive(1'b1, 21, 32'h0, mk(6, 5, 0));
    tick();
    chk("raw_hazard", bus.hazard, 1'b1);
    chk("raw_ready",  bus.in_ready, 1'b0);
    drive(1'b1, 22, 32'h0, mk(7, 0, 0));
    hc = 0;
    for (int t = 0; t < 8 && bus.hazard; t++) begin
      hc++;
      tick();
      if (t == 0) chk("raw_bubble1", bus.stage_valid[1], 1'b0);
    end
    chk("raw_stall_cycles", hc, 3);
    chk("raw_cleared", bus.hazard, 1'b0);
    chk("raw_ready_back", bus.in_ready, 1'b1);
    tick();
    // x0 never hazards.
    drive(1'b1, 23, 32'h1, mk(0, 0, 0));
    tick();
    drive(1'b1, 24, 32'h0, mk(8, 0, 0));
    tick();
    chk("x0_no_hazard", bus.hazard, 1'b0);
    // Match on rs2.
    drive(1'b1, 25, 32'h1, mk(9, 0, 0));
    tick();
    drive(1'b1, 26, 32'h0, mk(10, 3, 9));
    tick();
    chk("rs2_hazard", bus.hazard, 1'b1);
    idle();
    repeat (10) tick();

    // Flush: branch in stage 2, younger in 0 and 1.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 30+i, '0, mk(1, 0, 0));
      tick();
    end
    chk("flush_pre_valid", bus.stage_valid, 4'b0111);
    drive(1'b1, 33, '0, mk(1, 0, 0));
    bus.flush = 1'b1;
    #1;
    chk("flush_ready", bus.in_ready, 1'b0);
    tick();
    idle();
    chk("flush_valid", bus.stage_valid, 4'b1000);
    chk("flush_pc3",   pc_at(3), 30);
    repeat (4) tick();

    // Hold and flush together, then release hold with flush still high.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 40+i, '0, mk(1, 0, 0));
      tick();
    end
    chk("hold_pre_valid", bus.stage_valid, 4'b1111);
    snap_v  = bus.stage_valid;
    snap_pc = bus.stage_pc;
    drive(1'b1, 44, '0, mk(1, 0, 0));
    bus.ext_hold = 1'b1;
    bus.flush    = 1'b1;
    #1;
    chk("hold_retire0", bus.retire, 1'b0);
    chk("hold_ready",   bus.in_ready, 1'b0);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("hold_valid",  bus.stage_valid, snap_v);
      chk("hold_pc",     bus.stage_pc, snap_pc);
      chk("hold_retire", bus.retire, 1'b0);
    end
    bus.ext_hold = 1'b0;
    tick();
    idle();
    chk("holdflush_valid", bus.stage_valid, 4'b1000);
    chk("holdflush_pc3",   pc_at(3), 41);
    repeat (4) tick();

`ifdef PIPE_PERF_EN
    bus.perf_clr = 1'b1;
    tick();
    bus.perf_clr = 1'b0;
    chk("perf_clr0_ret", bus.perf_retired, 0);
    issue(50, 32'h1, mk(5, 0, 0));
    issue(51, 32'h0, mk(6, 5, 0));
    for (int i = 0; i < 8; i++) issue(52+i, 32'h0, mk(1, 0, 0));
    idle();
    repeat (10) tick();
    bus.flush = 1'b1;
    tick();
    idle();
    chk("perf_retired", bus.perf_retired, 10);
    chk("perf_bubbles", bus.perf_bubbles, 3);
    chk("perf_flushes", bus.perf_flushes, 1);
    bus.perf_clr = 1'b1;
    tick();
    bus.perf_clr = 1'b0;
    chk("perf_clr_ret", bus.perf_retired, 0);
    chk("perf_clr_bub", bus.perf_bubbles, 0);
    chk("perf_clr_fls", bus.perf_flushes, 0);
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
